instruction_fetch: RTL and testbench
====================================

// Module: instruction_fetch
// PURPOSE
//  Upstream stage of the single-cycle RV32I datapath. Holds the PC and an internal instruction ROM.
//  Presents instruction[31:0] to maincontrol, alucontrol and registerfile.
//  Computes next PC from the branch flag (maincontrol) and the zero flag (alu).
//  Halts on EBREAK/ECALL or on a fetch fault.
// PARAMETERS
//  IMEM_DEPTH  256            instruction words in ROM (power of 2)
//  RESET_PC    32'h0000_0000  PC loaded on reset (word aligned)
//  INIT_FILE   "program.hex"  $readmemh image loaded into ROM at time 0
// PORTS
//  clk            in   1   rising-edge clock
//  rst            in   1   asynchronous, active-high reset
//  stall          in   1   hold PC and state this cycle
//  branch         in   1   branch instruction decoded (maincontrol)
//  zero           in   1   ALU zero flag
//  branch_offset  in   32  sign-extended byte offset (B-imm, already <<1)
//  pc             out  32  current PC
//  instruction    out  32  fetched word; NOP 32'h0000_0013 when instr_valid=0
//  instr_valid    out  1   instruction is architecturally live
//  halted         out  1   fetch stopped; cleared only by rst
//  fault_code     out  2   00 none, 01 misaligned target, 10 PC out of range, 11 EBREAK/ECALL
//  taken_count    out  32  taken-branch counter (present only with FETCH_BRANCH_STATS_EN)
// BEHAVIOUR
//  - Reset (async, immediate): pc=RESET_PC, state=S_BOOT, instr_valid=0, halted=0, fault_code=00,
//    instruction=NOP, taken_count=0.
//  - FSM:
//    - S_BOOT: one cycle after rst deasserts, instr_valid=0; next edge -> S_RUN (stall ignored).
//    - S_RUN: instruction = rom[pc[ADDR_W+1:2]], combinational, zero-latency, same cycle as pc.
//      instr_valid=1 iff (pc>>2) < IMEM_DEPTH.
//    - S_HALT: pc frozen, instr_valid=0, instruction=NOP, halted=1. Exit only via rst.
//  - Next PC (S_RUN, !stall): target = (branch & zero) ? pc+branch_offset : pc+4.
//    32-bit modulo arithmetic, wrap at 2^32 is legal.
//  - Misaligned target (target[1:0]!=0): pc held, fault_code=01, -> S_HALT.
//  - Out of range ((pc>>2) >= IMEM_DEPTH in S_RUN): instr_valid=0, NOP out; next edge -> S_HALT,
//    fault_code=10, pc held.
//  - EBREAK (32'h0010_0073) or ECALL (32'h0000_0073) fetched: instr_valid=1 that cycle;
//    next non-stalled edge -> S_HALT, fault_code=11, pc held at that instruction.
//  - stall=1: pc, state, fault_code and taken_count unchanged; branch/zero ignored that cycle.
//    Upstream re-presents the branch after stall drops.
//  - Fault priority when coincident: EBREAK/ECALL > out-of-range > misaligned.
//  - fault_code is sticky until rst.
//  - rst asserted mid-stall or mid-halt: reset wins immediately.
// CONFIGURATION
//  FETCH_BRANCH_STATS_EN defined:
//    - taken_count port exists.
//    - Increments on each non-stalled S_RUN edge with branch&zero and an aligned target.
//    - Saturates at 32'hFFFF_FFFF. Reset to 0.
//  Undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - Shared header riscv_defs.vh holds: NOP/EBREAK/ECALL encodings, FSM state codes
//    (S_BOOT/S_RUN/S_HALT, 2-bit), fault_code values.
//  - One sub-module, pc_next: combinational target adder, taken select, alignment check.
//  - ROM, PC register, FSM and counter stay in the top.
// TESTING
//  1 Reset release, no stall, ROM of ADDIs:
//    -> cycle0 instr_valid=0; then pc=0,4,8,... with instr_valid=1 and matching words.
//  2 pc=8, branch=1, zero=1, offset=-8:
//    -> next pc=0; with zero=0 -> pc=12; taken_count=1 (FETCH_BRANCH_STATS_EN only).
//  3 stall=1 for 3 cycles at pc=16 with branch&zero:
//    -> pc stays 16; after stall drops, pc=16+4 if branch low.
//  4 offset=6 taken from pc=4 -> pc stays 4, fault_code=01, halted=1, instr_valid=0.
//  5 EBREAK at pc=12 -> instr_valid=1 one cycle, then halted=1, fault_code=11, pc=12;
//    rst -> pc=RESET_PC, halted=0.
//  6 IMEM_DEPTH=4, run sequentially -> pc=16 gives instr_valid=0 then fault_code=10;
//    async rst mid-cycle clears all outputs immediately.

Source files
------------

// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: RV32I encodings the
// fetch unit must recognise, FSM state codes and fault code values.
package instruction_fetch_pkg;

  localparam logic [31:0] INSTR_NOP    = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;

  typedef enum logic [1:0] {
    S_BOOT = 2'b00,
    S_RUN  = 2'b01,
    S_HALT = 2'b10
  } fetch_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'b00,
    FAULT_MISALIGN = 2'b01,
    FAULT_RANGE    = 2'b10,
    FAULT_SYSTEM   = 2'b11
  } fault_code_t;

  // EBREAK and ECALL both stop the fetch stage.
  function automatic logic is_system_instr(input logic [31:0] word);
    return (word == INSTR_EBREAK) || (word == INSTR_ECALL);
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC datapath: sequential and branch target adders, taken select and
// word-alignment check of the selected target. Purely combinational.
module instruction_fetch_pc_next (
  input  logic [31:0] i_pc,
  input  logic        i_branch,
  input  logic        i_zero,
  input  logic [31:0] i_branch_offset,
  output logic [31:0] o_target,
  output logic        o_misaligned
);

  logic        w_taken;
  logic [31:0] w_seq_target;
  logic [31:0] w_branch_target;

  // Both adders are plain 32-bit modulo sums; wrapping past 2^32 is legal.
  assign w_taken         = i_branch & i_zero;
  assign w_seq_target    = i_pc + 32'd4;
  assign w_branch_target = i_pc + i_branch_offset;
  assign o_target        = w_taken ? w_branch_target : w_seq_target;
  assign o_misaligned    = |o_target[1:0];

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage of the single-cycle RV32I datapath.
// Holds the PC, a word-addressed instruction ROM read combinationally in the
// same cycle as the PC, and a BOOT/RUN/HALT FSM that stops fetch on
// EBREAK/ECALL, an out-of-range PC or a misaligned next-PC target.
// ROM contents come from the IMEM_INIT image: word i sits at bits [32*i +: 32].
// Optional feature macro: FETCH_BRANCH_STATS_EN adds the taken_count port and
// a saturating taken-branch counter.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter int unsigned                IMEM_DEPTH = 256,
  parameter logic [31:0]                RESET_PC   = 32'h0000_0000,
  parameter logic [IMEM_DEPTH*32-1:0]   IMEM_INIT  = {IMEM_DEPTH{INSTR_NOP}}
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        instr_valid,
  output logic        halted,
  output logic [1:0]  fault_code
`ifdef FETCH_BRANCH_STATS_EN
  ,
  output logic [31:0] taken_count
`endif
);

  localparam int ADDR_W = $clog2(IMEM_DEPTH);

  fetch_state_t r_state;
  fetch_state_t w_state_next;
  fault_code_t  r_fault;
  fault_code_t  w_fault_next;
  logic [31:0]  r_pc;
  logic [31:0]  w_pc_next;

  logic [31:0]       w_rom [IMEM_DEPTH];
  logic [ADDR_W-1:0] w_index;
  logic [31:0]       w_rom_word;
  logic              w_in_range;
  logic              w_is_system;
  logic [31:0]       w_target;
  logic              w_misaligned;

  // ROM words are unpacked from the parameter image, one word per entry.
  for (genvar gi = 0; gi < IMEM_DEPTH; gi++) begin : g_rom
    assign w_rom[gi] = IMEM_INIT[gi*32 +: 32];
  end

  assign w_index     = r_pc[ADDR_W+1:2];
  assign w_in_range  = (r_pc >> (ADDR_W + 2)) == 32'd0;
  assign w_rom_word  = w_rom[w_index];
  assign w_is_system = w_in_range && is_system_instr(w_rom_word);

  instruction_fetch_pc_next u_pc_next (
    .i_pc            (r_pc),
    .i_branch        (branch),
    .i_zero          (zero),
    .i_branch_offset (branch_offset),
    .o_target        (w_target),
    .o_misaligned    (w_misaligned)
  );

  // State, PC and fault registers; reset takes effect immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_BOOT;
      r_pc    <= RESET_PC;
      r_fault <= FAULT_NONE;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_fault <= w_fault_next;
    end
  end

  // Next state / next PC with fault priority SYSTEM > RANGE > MISALIGN, plus outputs.
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_fault_next = r_fault;
    instr_valid  = 1'b0;
    instruction  = INSTR_NOP;
    halted       = 1'b0;
    unique case (r_state)
      S_BOOT: begin
        w_state_next = S_RUN;
      end
      S_RUN: begin
        instr_valid = w_in_range;
        instruction = w_in_range ? w_rom_word : INSTR_NOP;
        if (!stall) begin
          if (w_is_system) begin
            w_state_next = S_HALT;
            w_fault_next = FAULT_SYSTEM;
          end else if (!w_in_range) begin
            w_state_next = S_HALT;
            w_fault_next = FAULT_RANGE;
          end else if (w_misaligned) begin
            w_state_next = S_HALT;
            w_fault_next = FAULT_MISALIGN;
          end else begin
            w_pc_next = w_target;
          end
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        w_state_next = S_HALT;
        halted       = 1'b1;
      end
    endcase
  end

  assign pc         = r_pc;
  assign fault_code = r_fault;

`ifdef FETCH_BRANCH_STATS_EN
  logic        w_count_en;
  logic [31:0] r_taken_count;

  // Count only branches that actually redirect the PC (no higher-priority fault).
  assign w_count_en = (r_state == S_RUN) && !stall && w_in_range && !w_is_system &&
                      !w_misaligned && branch && zero;

  // Saturating taken-branch counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_taken_count <= 32'd0;
    end else if (w_count_en && (r_taken_count != 32'hFFFF_FFFF)) begin
      r_taken_count <= r_taken_count + 32'd1;
    end
  end

  assign taken_count = r_taken_count;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios followed by
// randomized stall/branch/offset traffic, checked every cycle against a
// behavioural model of the fetch stage. Build with FETCH_BRANCH_STATS_EN
// defined to also check taken_count.
module tb_instruction_fetch;

  localparam int          DEPTH  = 16;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [31:0] EBRK   = 32'h0010_0073;
  localparam logic [31:0] ECLL   = 32'h0000_0073;

  // Program: ADDI x1,x1,i everywhere except EBREAK at pc 12 and ECALL at pc 36.
  function automatic logic [31:0] prog_word(input int i);
    logic [31:0] w;
    if (i == 3)      w = EBRK;
    else if (i == 9) w = ECLL;
    else             w = (32'(i) << 20) | (32'd1 << 15) | (32'd1 << 7) | 32'h13;
    return w;
  endfunction

  function automatic logic [DEPTH*32-1:0] build_image();
    logic [DEPTH*32-1:0] img;
    img = '0;
    for (int i = 0; i < DEPTH; i++) img[i*32 +: 32] = prog_word(i);
    return img;
  endfunction

  localparam logic [DEPTH*32-1:0] IMAGE = build_image();

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch;
  logic        zero;
  logic [31:0] branch_offset;
  logic [31:0] pc;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        halted;
  logic [1:0]  fault_code;
`ifdef FETCH_BRANCH_STATS_EN
  logic [31:0] taken_count;
`endif

  instruction_fetch #(
    .IMEM_DEPTH (DEPTH),
    .RESET_PC   (RST_PC),
    .IMEM_INIT  (IMAGE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stall         (stall),
    .branch        (branch),
    .zero          (zero),
    .branch_offset (branch_offset),
    .pc            (pc),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .halted        (halted),
    .fault_code    (fault_code)
`ifdef FETCH_BRANCH_STATS_EN
    ,
    .taken_count   (taken_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model: phase 0 = just out of reset, 1 = fetching, 2 = stopped.
  int          m_phase;
  logic [31:0] m_pc;
  logic [1:0]  m_fault;
  logic [31:0] m_count;

  int checks;
  int failures;
  int step_no;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s step=%0d observed=%h expected=%h", tag, step_no, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic        exp_valid;
    logic [31:0] exp_instr;
    exp_valid = (m_phase == 1) && ((m_pc >> 2) < 32'(DEPTH));
    exp_instr = exp_valid ? prog_word(int'(m_pc >> 2)) : NOP;
    chk("pc", pc, m_pc);
    chk("instruction", instruction, exp_instr);
    chk("instr_valid", 32'(instr_valid), 32'(exp_valid));
    chk("halted", 32'(halted), 32'(m_phase == 2));
    chk("fault_code", 32'(fault_code), 32'(m_fault));
`ifdef FETCH_BRANCH_STATS_EN
    chk("taken_count", taken_count, m_count);
`endif
  endtask

  // Apply one clock edge worth of inputs to the model.
  task automatic model_edge(input logic s, input logic b, input logic z, input logic [31:0] off);
    logic [31:0] nxt;
    logic        in_range;
    logic [31:0] word;
    if (m_phase == 0) begin
      m_phase = 1;
    end else if (m_phase == 1 && !s) begin
      in_range = (m_pc >> 2) < 32'(DEPTH);
      word     = in_range ? prog_word(int'(m_pc >> 2)) : NOP;
      if (in_range && (word == EBRK || word == ECLL)) begin
        m_phase = 2; m_fault = 2'b11;
      end else if (!in_range) begin
        m_phase = 2; m_fault = 2'b10;
      end else begin
        nxt = (b && z) ? m_pc + off : m_pc + 32'd4;
        if (nxt % 4 != 0) begin
          m_phase = 2; m_fault = 2'b01;
        end else begin
          m_pc = nxt;
          if (b && z && m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
        end
      end
    end
  endtask

  // One transaction: drive inputs just after a rising edge, check on the
  // falling edge, advance the model, move to just after the next rising edge.
  task automatic step(input logic s, input logic b, input logic z, input logic [31:0] off);
    stall = s; branch = b; zero = z; branch_offset = off;
    @(negedge clk);
    check_outputs();
    $display("step %0d stall=%b br=%b z=%b off=%h | pc=%h instr=%h valid=%b halted=%b fc=%0d",
             step_no, s, b, z, off, pc, instruction, instr_valid, halted, fault_code);
    step_no++;
    model_edge(s, b, z, off);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse between clock edges; outputs must clear at once.
  task automatic do_reset();
    rst = 1'b1;
    m_phase = 0; m_pc = RST_PC; m_fault = 2'b00; m_count = 32'd0;
    #2;
    check_outputs();
    $display("reset step %0d | pc=%h valid=%b halted=%b fc=%0d", step_no, pc, instr_valid,
             halted, fault_code);
    rst = 1'b0;
  endtask

  logic [31:0] off_tab [10];
  int          halt_cycles;

  initial begin
    checks = 0; failures = 0; step_no = 0;
    rst = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0; branch_offset = 32'd0;
    m_phase = 0; m_pc = RST_PC; m_fault = 2'b00; m_count = 32'd0;
    off_tab = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'd4, 32'd8, 32'd12, 32'd16,
                32'hFFFF_FFF0, 32'd2, 32'h0000_0100, 32'd6};
    @(posedge clk);
    #1;

    // Sequential fetch, taken branch back, not-taken branch, EBREAK halt.
    do_reset();
    step(0, 0, 0, 32'd0);          // boot cycle
    step(0, 0, 0, 32'd0);          // pc 0
    step(0, 0, 0, 32'd0);          // pc 4
    step(0, 1, 1, 32'hFFFF_FFF8);  // pc 8, taken -8
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    step(0, 1, 0, 32'hFFFF_FFF8);  // pc 8, not taken
    step(1, 0, 0, 32'd0);          // EBREAK held by stall
    step(0, 0, 0, 32'd0);          // EBREAK retires into halt
    step(1, 1, 1, 32'd4);
    step(0, 1, 1, 32'd4);

    // Reset mid-halt, stall with branch pending, run off the end of ROM.
    do_reset();
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    step(0, 1, 1, 32'd8);          // pc 8 -> 16
    for (int i = 0; i < 3; i++) step(1, 1, 1, 32'd8);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 32'd0);  // 16..32
    step(0, 1, 1, 32'd8);          // pc 32 -> 40, skipping ECALL
    for (int i = 0; i < 6; i++) step(0, 0, 0, 32'd0);  // 40..64
    step(0, 0, 0, 32'd0);          // pc 64 out of range
    step(0, 0, 0, 32'd0);

    // Misaligned branch target.
    do_reset();
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);
    step(0, 1, 1, 32'd6);          // pc 4 + 6
    step(1, 0, 0, 32'd0);

    // Stall ignored during boot, then reset while stalled.
    do_reset();
    step(1, 1, 1, 32'd8);
    step(1, 1, 1, 32'd8);
    step(1, 0, 0, 32'd0);
    do_reset();

    // Branch that wraps past 2^32.
    step(0, 0, 0, 32'd0);
    step(0, 1, 1, 32'hFFFF_FFFC);  // pc 0 -> FFFF_FFFC
    step(0, 0, 0, 32'd0);
    step(0, 0, 0, 32'd0);

    // Randomized traffic; reset a couple of cycles after each halt.
    do_reset();
    halt_cycles = 0;
    for (int n = 0; n < 400; n++) begin
      if (m_phase == 2) begin
        halt_cycles++;
        if (halt_cycles > 2) begin
          halt_cycles = 0;
          do_reset();
        end
      end
      step(($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           off_tab[$urandom_range(0, 9)]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
